// File: rtl/delay_scheduler.sv
// Shares one elapsed-cycle counter among N requesters, granting it round-robin
// and pulsing done to the owner when its latched delay length has elapsed.
module delay_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] len,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               busy,
  output logic [WIDTH-1:0]   elapsed
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [N-1:0]     grant_q;
  logic [N-1:0]     done_q;
  logic             busy_q;
  logic [WIDTH-1:0] elapsed_q;
  logic [WIDTH-1:0] len_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    winner_q;

  logic             win_found_d;
  logic [IW-1:0]    win_idx_d;
  logic [N-1:0]     win_onehot_d;
  logic [WIDTH-1:0] win_len_d;

  // Scan from the slot after the previous owner; walking the offsets downward
  // lets the nearest pending requester overwrite any farther one.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    int cand;
    cand         = 0;
    win_found_d  = 1'b0;
    win_idx_d    = '0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(last_q) + off) % N;
      if (req[IW'(cand)]) begin
        win_found_d = 1'b1;
        win_idx_d   = IW'(cand);
      end
    end
    win_onehot_d            = '0;
    win_onehot_d[win_idx_d] = 1'b1;
    win_len_d               = len[win_idx_d*WIDTH +: WIDTH];
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      elapsed_q <= '0;
      len_q     <= '0;
      last_q    <= IW'(N - 1);
      winner_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_found_d) begin
            winner_q  <= win_idx_d;
            grant_q   <= win_onehot_d;
            len_q     <= win_len_d;
            elapsed_q <= '0;
            busy_q    <= 1'b1;
            if (win_len_d == '0) begin
              state_q <= DONE;
              done_q  <= win_onehot_d;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // A dropped request abandons the delay and takes priority over completion.
          if (!req[winner_q]) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            elapsed_q <= '0;
            last_q    <= winner_q;
          end else if (elapsed_q == len_q - WIDTH'(1)) begin
            state_q   <= DONE;
            elapsed_q <= len_q;
            done_q    <= grant_q;
          end else begin
            elapsed_q <= elapsed_q + WIDTH'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          done_q    <= '0;
          busy_q    <= 1'b0;
          elapsed_q <= '0;
          last_q    <= winner_q;
        end
        default: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          done_q    <= '0;
          busy_q    <= 1'b0;
          elapsed_q <= '0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign elapsed = elapsed_q;

endmodule
